// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode encodings.
// Helpers take full-width operands; callers zero-extend and truncate to their own width.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] value);
        return value ^ (value >> 1);
    endfunction

    // Zero-extended upper bits keep the prefix XOR exact for narrower counters.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] value);
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin[GRAY_MAX_WIDTH-1] = value[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ value[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_err_check.sv
// Single-bit-change monitor for the Gray output: flags any non-wrap count step
// whose Gray value changed in anything other than exactly one bit. Sticky until rst.
module gray_err_check #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] count_out,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] prev_gray;
    logic                  step_q;
    logic                  one_bit;

    assign one_bit = ($countones(count_out ^ prev_gray) == 1);

    // step_q marks that the value now on count_out came from a plain +/-1 step.
    always_ff @(posedge clk) begin
        prev_gray <= count_out;
        if (rst) begin
            step_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            step_q <= step;
            err    <= err | (step_q & ~one_bit);
        end
    end

endmodule

// File: rtl/gray_counter_ud.sv
// Up/down Gray counter with load, programmable limit and wrap/saturate modes.
// Define GRAY_COUNTER_UD_ERR_CHECK_EN to add the sticky single-bit-change err output.
module gray_counter_ud
    import gray_pkg::*;
#(
    parameter int                    DATA_WIDTH = 4,
    parameter int                    SATURATE   = 0,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic [DATA_WIDTH-1:0] limit,
    output logic [DATA_WIDTH-1:0] count_bin,
    output logic [DATA_WIDTH-1:0] count_out,
    output logic                  tc
`ifdef GRAY_COUNTER_UD_ERR_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam bit SAT_MODE = (SATURATE == MODE_SAT);

    logic [DATA_WIDTH-1:0] next_bin;
    logic                  next_tc;

    // Bound hits raise tc; saturate mode reloads the same bound, so a held counter keeps pulsing.
    always_comb begin
        next_bin = count_bin;
        next_tc  = 1'b0;
        if (load) begin
            next_bin = load_val;
        end else if (en) begin
            if (up) begin
                if (count_bin >= limit) begin
                    next_bin = SAT_MODE ? limit : '0;
                    next_tc  = 1'b1;
                end else begin
                    next_bin = count_bin + DATA_WIDTH'(1);
                end
            end else begin
                if (count_bin == '0) begin
                    next_bin = SAT_MODE ? '0 : limit;
                    next_tc  = 1'b1;
                end else begin
                    next_bin = count_bin - DATA_WIDTH'(1);
                end
            end
        end
    end

    // Gray is encoded from the next binary value so both outputs update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_bin <= RST_VAL;
            count_out <= DATA_WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RST_VAL)));
            tc        <= 1'b0;
        end else begin
            count_bin <= next_bin;
            count_out <= DATA_WIDTH'(bin2gray(GRAY_MAX_WIDTH'(next_bin)));
            tc        <= next_tc;
        end
    end

`ifdef GRAY_COUNTER_UD_ERR_CHECK_EN
    logic step;

    assign step = en & ~load & ~next_tc;

    gray_err_check #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_err_check (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .count_out(count_out),
        .err      (err)
    );
`endif

endmodule

// File: tb/tb_gray_counter_ud.sv
// Bench for gray_counter_ud: three instances (wrap, saturate, RST_VAL=3) against an integer model.
// Define GRAY_COUNTER_UD_ERR_CHECK_EN to also exercise the err output.
module tb_gray_counter_ud;

    localparam int NUM_DUT = 3;
    localparam int SAT_OF [NUM_DUT] = '{0, 1, 0};
    localparam int RV_OF  [NUM_DUT] = '{0, 0, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'h0;
    logic [3:0] limit = 4'hF;

    logic [3:0] bin_w  [NUM_DUT];
    logic [3:0] gray_w [NUM_DUT];
    logic       tc_w   [NUM_DUT];
`ifdef GRAY_COUNTER_UD_ERR_CHECK_EN
    logic       err_w  [NUM_DUT];
`endif

    int total = 0;
    int bad = 0;

    int m_cnt [NUM_DUT];
    int m_tc  [NUM_DUT];

    typedef struct {
        bit         rst;
        bit         en;
        bit         up;
        bit         load;
        logic [3:0] load_val;
        logic [3:0] limit;
        logic [3:0] exp_bin;
        logic [3:0] exp_gray;
        bit         exp_tc;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    gray_counter_ud #(.DATA_WIDTH(4), .SATURATE(0), .RST_VAL(4'd0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .limit(limit),
        .count_bin(bin_w[0]), .count_out(gray_w[0]), .tc(tc_w[0])
`ifdef GRAY_COUNTER_UD_ERR_CHECK_EN
        , .err(err_w[0])
`endif
    );

    gray_counter_ud #(.DATA_WIDTH(4), .SATURATE(1), .RST_VAL(4'd0)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .limit(limit),
        .count_bin(bin_w[1]), .count_out(gray_w[1]), .tc(tc_w[1])
`ifdef GRAY_COUNTER_UD_ERR_CHECK_EN
        , .err(err_w[1])
`endif
    );

    gray_counter_ud #(.DATA_WIDTH(4), .SATURATE(0), .RST_VAL(4'd3)) dut_r3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .limit(limit),
        .count_bin(bin_w[2]), .count_out(gray_w[2]), .tc(tc_w[2])
`ifdef GRAY_COUNTER_UD_ERR_CHECK_EN
        , .err(err_w[2])
`endif
    );

    function automatic int gray_of(input int n);
        return n ^ (n >> 1);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference behaviour straight from the counting rules, in plain integers.
    task automatic modelEdge();
        for (int i = 0; i < NUM_DUT; i++) begin
            if (rst) begin
                m_cnt[i] = RV_OF[i];
                m_tc[i]  = 0;
            end else if (load) begin
                m_cnt[i] = int'(load_val);
                m_tc[i]  = 0;
            end else if (en && up) begin
                if (m_cnt[i] >= int'(limit)) begin
                    m_cnt[i] = (SAT_OF[i] == 1) ? int'(limit) : 0;
                    m_tc[i]  = 1;
                end else begin
                    m_cnt[i] = (m_cnt[i] + 1) % 16;
                    m_tc[i]  = 0;
                end
            end else if (en) begin
                if (m_cnt[i] == 0) begin
                    m_cnt[i] = (SAT_OF[i] == 1) ? 0 : int'(limit);
                    m_tc[i]  = 1;
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                    m_tc[i]  = 0;
                end
            end else begin
                m_tc[i] = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name);
        for (int i = 0; i < NUM_DUT; i++) begin
            check($sformatf("%s bin[%0d]", name, i), int'(bin_w[i]), m_cnt[i]);
            check($sformatf("%s gray[%0d]", name, i), int'(gray_w[i]), gray_of(m_cnt[i]));
            check($sformatf("%s tc[%0d]", name, i), int'(tc_w[i]), m_tc[i]);
        end
    endtask

    task automatic tick(input bit do_check, input string name);
        @(posedge clk);
        modelEdge();
        #1;
        if (do_check) checkOutput(name);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        en       = v.en;
        up       = v.up;
        load     = v.load;
        load_val = v.load_val;
        limit    = v.limit;
    endtask

    task automatic setIdle();
        rst  = 1'b0;
        en   = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] gray_seq [16];
        logic [3:0] sat_bin [5];
        bit         sat_tc [5];
        logic [3:0] prev_gray;

        gray_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                     4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        sat_bin  = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
        sat_tc   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        //           rst en up ld  ld_val limit  bin    gray   tc
        vecs[0]  = '{1, 0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 0};
        vecs[1]  = '{0, 1, 0, 0, 4'h0, 4'h5, 4'h5, 4'h7, 1};
        vecs[2]  = '{0, 1, 0, 0, 4'h0, 4'h5, 4'h4, 4'h6, 0};
        vecs[3]  = '{0, 1, 0, 0, 4'h0, 4'h5, 4'h3, 4'h2, 0};
        vecs[4]  = '{0, 1, 1, 1, 4'hA, 4'hF, 4'hA, 4'hF, 0};
        vecs[5]  = '{1, 1, 1, 1, 4'hA, 4'hF, 4'h0, 4'h0, 0};
        vecs[6]  = '{0, 1, 1, 0, 4'h0, 4'hF, 4'h1, 4'h1, 0};
        vecs[7]  = '{0, 0, 1, 0, 4'h0, 4'hF, 4'h1, 4'h1, 0};
        vecs[8]  = '{0, 0, 1, 1, 4'h7, 4'h5, 4'h7, 4'h4, 0};
        vecs[9]  = '{0, 1, 1, 0, 4'h0, 4'h5, 4'h0, 4'h0, 1};
        vecs[10] = '{0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1};
        vecs[11] = '{0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1};

        for (int i = 0; i < NUM_DUT; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 0;
        end

        // Table-driven vectors, expected values for the wrap-mode instance.
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(vecs[k]);
            tick(1'b1, $sformatf("vec%0d", k));
            check($sformatf("vec%0d tbl_bin", k), int'(bin_w[0]), int'(vecs[k].exp_bin));
            check($sformatf("vec%0d tbl_gray", k), int'(gray_w[0]), int'(vecs[k].exp_gray));
            check($sformatf("vec%0d tbl_tc", k), int'(tc_w[0]), int'(vecs[k].exp_tc));
        end

        // Full up-count cycle through all 16 Gray codes.
        setIdle();
        rst = 1'b1;
        tick(1'b1, "seq_reset");
        rst   = 1'b0;
        en    = 1'b1;
        up    = 1'b1;
        limit = 4'hF;
        prev_gray = gray_w[0];
        for (int k = 0; k < 16; k++) begin
            tick(1'b1, $sformatf("up%0d", k));
            check($sformatf("up%0d seq_gray", k), int'(gray_w[0]), int'(gray_seq[k]));
            check($sformatf("up%0d seq_tc", k), int'(tc_w[0]), (k == 15) ? 1 : 0);
            check($sformatf("up%0d one_bit", k), $countones(gray_w[0] ^ prev_gray), 1);
            prev_gray = gray_w[0];
        end

        // Saturate at limit 9 starting from 7.
        setIdle();
        load     = 1'b1;
        load_val = 4'd7;
        limit    = 4'd9;
        tick(1'b1, "sat_load");
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, $sformatf("sat%0d", k));
            check($sformatf("sat%0d sat_bin", k), int'(bin_w[1]), int'(sat_bin[k]));
            check($sformatf("sat%0d sat_tc", k), int'(tc_w[1]), int'(sat_tc[k]));
        end

        // Mid-count reset on the RST_VAL=3 instance.
        setIdle();
        load     = 1'b1;
        load_val = 4'd5;
        limit    = 4'hF;
        tick(1'b1, "r3_load");
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        tick(1'b1, "r3_to6");
        check("r3 at6", int'(bin_w[2]), 6);
        rst = 1'b1;
        tick(1'b1, "r3_rst");
        check("r3 rst_bin", int'(bin_w[2]), 3);
        check("r3 rst_gray", int'(gray_w[2]), 2);
        check("r3 rst_tc", int'(tc_w[2]), 0);
        rst = 1'b0;
        tick(1'b1, "r3_resume");
        check("r3 resume_bin", int'(bin_w[2]), 4);

        // Randomised traffic; limit only moves while counting is disabled.
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 40) == 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 1) == 1);
            load_val = 4'($urandom_range(0, 15));
            if (!en) limit = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            tick(1'b1, "rand");
        end

`ifdef GRAY_COUNTER_UD_ERR_CHECK_EN
        setIdle();
        rst = 1'b1;
        tick(1'b1, "err_rst");
        for (int i = 0; i < NUM_DUT; i++) check($sformatf("err_reset[%0d]", i), int'(err_w[i]), 0);
        rst   = 1'b0;
        load  = 1'b1;
        load_val = 4'h0;
        limit = 4'hF;
        tick(1'b1, "err_load");
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        tick(1'b1, "err_step");
        check("err_clean", int'(err_w[0]), 0);
        force dut.count_out = 4'b0011;
        en = 1'b0;
        tick(1'b0, "err_flip");
        release dut.count_out;
        tick(1'b1, "err_restore");
        check("err_set", int'(err_w[0]), 1);
        check("err_other", int'(err_w[1]), 0);
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, "err_hold");
            check("err_sticky", int'(err_w[0]), 1);
        end
        rst = 1'b1;
        tick(1'b1, "err_clear");
        check("err_cleared", int'(err_w[0]), 0);
        rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
